// File: rtl/coil_pwm_pkg.sv
// Shared types and helpers for the coil PWM driver.
// State encodings, the one-hot test and the all-off pattern.
package coil_pwm_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DEAD  = 2'd1,
    BOOST = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] ALL_OFF = 4'b0000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/coil_pwm_gen.sv
// Free-running hold PWM counter with synchronous clear.
// pwm_on compares the count the next cycle will carry.
module coil_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] nxt;

  assign nxt    = clr ? '0 : cnt + PWM_BITS'(1);
  // Looking at the next count lets the registered coil output
  // line up with the counter value of the same cycle.
  assign pwm_on = nxt < duty;

  // Counter wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= nxt;
  end

endmodule

// File: rtl/coil_pwm_driver.sv
// Coil driver: dead time, boost, then PWM hold.
// Non-one-hot requests are ignored and flagged on fault.
module coil_pwm_driver
  import coil_pwm_pkg::*;
#(
  parameter int DEAD_CYCLES  = 16,
  parameter int BOOST_CYCLES = 20000,
  parameter int PWM_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          coils_in,
  input  logic [PWM_BITS-1:0] hold_duty,
  output logic [3:0]          coil_out,
  output logic                busy,
  output logic                fault
);

  localparam int DW =
    (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int BW =
    (BOOST_CYCLES > 1) ? $clog2(BOOST_CYCLES) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [BW-1:0] BLOAD = BW'(BOOST_CYCLES - 1);

  state_t        state;
  logic [3:0]    latch;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt;
  logic          valid;
  logic          chg;
  logic          pwm_clr;
  logic          pwm_on;

  assign valid   = is_onehot4(coils_in);
  assign chg     = valid && (coils_in != latch);
  assign pwm_clr = en && (state == BOOST) && !chg
                   && (bcnt == '0);

  coil_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (pwm_clr),
    .duty   (hold_duty),
    .pwm_on (pwm_on)
  );

  // Sequencing FSM; all outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= OFF;
      latch    <= ALL_OFF;
      dcnt     <= '0;
      bcnt     <= '0;
      coil_out <= ALL_OFF;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      fault <= ~valid;
      if (!en) begin
        state    <= OFF;
        coil_out <= ALL_OFF;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          OFF: begin
            coil_out <= ALL_OFF;
            if (valid) begin
              latch <= coils_in;
              dcnt  <= DLOAD;
              state <= DEAD;
              busy  <= 1'b1;
            end
          end
          DEAD: begin
            // A change here only swaps the pattern;
            // the dead period keeps its original end.
            if (chg) latch <= coils_in;
            if (dcnt == '0) begin
              bcnt     <= BLOAD;
              state    <= BOOST;
              coil_out <= chg ? coils_in : latch;
            end else begin
              dcnt     <= dcnt - DW'(1);
              coil_out <= ALL_OFF;
            end
            busy <= 1'b1;
          end
          BOOST: begin
            if (chg) begin
              latch    <= coils_in;
              dcnt     <= DLOAD;
              state    <= DEAD;
              coil_out <= ALL_OFF;
            end else if (bcnt == '0) begin
              state    <= HOLD;
              busy     <= 1'b0;
              coil_out <= pwm_on ? latch : ALL_OFF;
            end else begin
              bcnt     <= bcnt - BW'(1);
              coil_out <= latch;
            end
          end
          HOLD: begin
            if (chg) begin
              latch    <= coils_in;
              dcnt     <= DLOAD;
              state    <= DEAD;
              busy     <= 1'b1;
              coil_out <= ALL_OFF;
            end else begin
              coil_out <= pwm_on ? latch : ALL_OFF;
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coil_pwm_driver.sv
// Directed bench for coil_pwm_driver.
// DEAD_CYCLES=4, BOOST_CYCLES=10, PWM_BITS=4.
module tb_coil_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cin = 4'b0000;
  logic [3:0] duty = 4'd4;
  logic [3:0] coil_out;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cin;
    logic [3:0] coil;
    logic       busy;
    logic       fault;
  } vec_t;

  vec_t tbl[9];

  coil_pwm_driver #(
    .DEAD_CYCLES  (4),
    .BOOST_CYCLES (10),
    .PWM_BITS     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .coils_in  (cin),
    .hold_duty (duty),
    .coil_out  (coil_out),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [3:0] c,
                         input logic b,
                         input logic f);
    chk({nm, ".coil"}, {28'b0, coil_out}, {28'b0, c});
    chk({nm, ".busy"}, {31'b0, busy}, {31'b0, b});
    chk({nm, ".fault"}, {31'b0, fault}, {31'b0, f});
  endtask

  // One clock edge, then sample; coil_out never has two bits.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", {31'b0, ($countones(coil_out) <= 1)}, 32'd1);
  endtask

  task automatic dead_boost(input string nm, input logic [3:0] p);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out({nm, ".dead"}, 4'b0000, 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out({nm, ".boost"}, p, 1'b1, 1'b0);
    end
  endtask

  initial begin
    int on;
    tbl[0] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0};

    // Reset, invalid input in OFF, power-up dead period.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      en  = tbl[i].en;
      cin = tbl[i].cin;
      tick();
      chk_out($sformatf("tbl%0d", i),
              tbl[i].coil, tbl[i].busy, tbl[i].fault);
    end

    // Rest of boost, with 0110 injected for 3 cycles.
    for (int i = 0; i < 9; i++) begin
      cin = (i >= 2 && i <= 4) ? 4'b0110 : 4'b0001;
      tick();
      chk_out("boost1", 4'b0001, 1'b1, (i >= 2 && i <= 4));
    end
    cin = 4'b0001;

    // Hold at duty 4: on for 4 of every 16.
    for (int k = 0; k < 32; k++) begin
      tick();
      chk_out("hold4", ((k % 16) < 4) ? 4'b0001 : 4'b0000,
              1'b0, 1'b0);
    end

    // Change during HOLD.
    cin = 4'b0010;
    tick();
    chk_out("chg_hold", 4'b0000, 1'b1, 1'b0);
    dead_boost("seq2", 4'b0010);
    tick();
    chk_out("hold_entry2", 4'b0010, 1'b0, 1'b0);

    // Changes inside DEAD keep the original end.
    cin = 4'b1000;
    tick();
    chk_out("d0", 4'b0000, 1'b1, 1'b0);
    cin = 4'b0010;
    tick();
    chk_out("d1", 4'b0000, 1'b1, 1'b0);
    cin = 4'b0100;
    tick();
    chk_out("d2", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_out("d3", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_out("d_end", 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out("boost3", 4'b0100, 1'b1, 1'b0);
    end

    // Change on the last boost cycle wins over HOLD.
    cin = 4'b0001;
    tick();
    chk_out("bcnt0_chg", 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("dead4", 4'b0000, 1'b1, 1'b0);
    end
    // Change on dcnt==0 boosts with the new pattern.
    cin = 4'b1000;
    tick();
    chk_out("dcnt0_chg", 4'b1000, 1'b1, 1'b0);

    // Drop en mid-boost, then en=0 with a change.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("boost5", 4'b1000, 1'b1, 1'b0);
    end
    en = 1'b0;
    tick();
    chk_out("en_off", 4'b0000, 1'b0, 1'b0);
    cin = 4'b0100;
    tick();
    chk_out("en_off_chg", 4'b0000, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk_out("en_on", 4'b0000, 1'b1, 1'b0);
    dead_boost("seq5", 4'b0100);
    tick();
    chk_out("hold_entry5", 4'b0100, 1'b0, 1'b0);

    // Duty sweep: on-cycles per 16-cycle window.
    for (int j = 0; j < 3; j++) begin
      duty = (j == 0) ? 4'd0 : (j == 1) ? 4'd8 : 4'd15;
      on = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (coil_out == 4'b0100) on++;
        else if (coil_out != 4'b0000) on += 100;
      end
      chk($sformatf("duty%0d", duty), on, {28'b0, duty});
    end

    // Reset during HOLD with a fault pending.
    duty = 4'd4;
    cin = 4'b0110;
    tick();
    chk("hold_fault", {31'b0, fault}, 32'd1);
    chk("hold_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    chk_out("rst_hold", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    cin = 4'b0100;
    tick();
    chk_out("rst_restart", 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_dead", 4'b0000, 1'b1, 1'b0);
    end
    tick();
    chk_out("rst_boost", 4'b0100, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
